// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI slave front end of the SPI-to-RAM path.
//   - FRAME_W_DEF / DATA_W_DEF : default command-word and read-data widths
//   - CMD_*                    : 2-bit command codes carried in payload[9:8]
//   - spi_state_t              : receive FSM states
// Optional feature macro used by importers: SPI_CMD_CHECK_EN
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int FRAME_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// Bundles the serial pins and the RAM-side word interface of spi_slave.
//   SS_n, MOSI, MISO   : serial link (SCK is the system clock)
//   rx_data, rx_valid  : assembled command word towards the RAM controller
//   tx_data, tx_valid  : read data returned by the RAM controller
//   cmd_err            : command check error strobe (SPI_CMD_CHECK_EN only)
// Modports: slave (the SPI slave block), master (its environment).
// -----------------------------------------------------------------------------
interface spi_slave_if
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;
    logic               cmd_err;

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid, cmd_err
    );

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid, cmd_err
    );
endinterface

// File: rtl/spi_miso_shifter.sv
// -----------------------------------------------------------------------------
// spi_miso_shifter
// Parallel-load, MSB-first serialiser for read data on MISO.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : synchronous abort (slave deselected); drops MISO to 0
//   load       : capture din and drive din[MSB] on the same edge
//   din        : read data word
//   miso       : serial output, 0 whenever idle
//   done       : one-cycle pulse on the edge MISO returns to 0 after the LSB
// -----------------------------------------------------------------------------
module spi_miso_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              miso,
    output logic              done
);
    localparam int CNT_W = $clog2(DATA_W);

    // Only the bits still to be sent are kept; the MSB goes out at load time.
    logic [DATA_W-2:0] shift_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;
    logic              miso_reg;
    logic              done_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            miso_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load && !busy_reg) begin
                miso_reg  <= din[DATA_W-1];
                shift_reg <= din[DATA_W-2:0];
                cnt_reg   <= CNT_W'(DATA_W-1);
                busy_reg  <= 1'b1;
            end else if (busy_reg) begin
                if (cnt_reg != '0) begin
                    miso_reg  <= shift_reg[DATA_W-2];
                    shift_reg <= {shift_reg[DATA_W-3:0], 1'b0};
                    cnt_reg   <= cnt_reg - CNT_W'(1);
                end else begin
                    // LSB has had its full bit time; return the line to 0.
                    miso_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign miso = miso_reg;
    assign done = done_reg;
endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI slave front end: receives {select bit, FRAME_W payload bits} MSB first
// while SS_n is low, presents the payload as a command word (rx_data with a
// one-cycle rx_valid), and serialises RAM read data (tx_data/tx_valid) onto
// MISO after a read-data frame. A read-data frame is only possible after a
// read-address frame has set the internal rd_addr_flag.
//   clk   : system clock, doubles as SCK (rising edge)
//   rst_n : synchronous active-low reset
//   bus   : spi_slave_if.slave (SS_n, MOSI, MISO, rx_data, rx_valid,
//           tx_data, tx_valid, cmd_err)
// Optional: define SPI_CMD_CHECK_EN to reject words whose payload[9:8] does
// not match the path selected; rejected words raise cmd_err instead of
// rx_valid. Without it cmd_err is tied low.
// -----------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_slave_if.slave  bus
);
    localparam int CNT_W = $clog2(FRAME_W + 1);

    spi_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [FRAME_W-2:0] rx_shift_reg;
    logic [FRAME_W-1:0] rx_data_reg;
    logic               rx_valid_reg;
    logic               rd_addr_flag_reg;
    logic               rd_armed_reg;      // read-data word accepted, waiting for tx_valid

    logic               in_payload;
    logic               frame_last;
    logic               cmd_ok;
    logic [FRAME_W-1:0] word_next;
    logic               miso_load;
    logic               miso_done;
    logic               miso_bit;

    assign in_payload = (state_reg == WRITE) || (state_reg == READ_ADD) ||
                        (state_reg == READ_DATA);
    // Edge on which the last payload bit arrives; the counter stops at FRAME_W
    // so trailing bits with SS_n still low never re-trigger this.
    assign frame_last = in_payload && !bus.SS_n &&
                        (bit_cnt_reg == CNT_W'(FRAME_W - 1));
    assign word_next  = {rx_shift_reg, bus.MOSI};

`ifdef SPI_CMD_CHECK_EN
    logic [1:0] cmd_code;
    logic       cmd_err_reg;

    assign cmd_code = word_next[FRAME_W-1 -: 2];

    always_comb begin
        cmd_ok = 1'b0;
        case (state_reg)
            WRITE:     cmd_ok = (cmd_code == CMD_WR_ADDR) || (cmd_code == CMD_WR_DATA);
            READ_ADD:  cmd_ok = (cmd_code == CMD_RD_ADDR);
            READ_DATA: cmd_ok = (cmd_code == CMD_RD_DATA);
            default:   cmd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_err_reg <= 1'b0;
        end else begin
            cmd_err_reg <= frame_last && !cmd_ok;
        end
    end

    assign bus.cmd_err = cmd_err_reg;
`else
    assign cmd_ok      = 1'b1;
    assign bus.cmd_err = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!bus.SS_n) state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n)              state_next = IDLE;
                else if (!bus.MOSI)        state_next = WRITE;
                else if (rd_addr_flag_reg) state_next = READ_DATA;
                else                       state_next = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Receive datapath, word strobe and read bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_reg      <= '0;
            rx_shift_reg     <= '0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            rd_addr_flag_reg <= 1'b0;
            rd_armed_reg     <= 1'b0;
        end else begin
            rx_valid_reg <= frame_last && cmd_ok;

            if (bus.SS_n) begin
                bit_cnt_reg <= '0;
            end else if (in_payload && (bit_cnt_reg != CNT_W'(FRAME_W))) begin
                rx_shift_reg <= word_next[FRAME_W-2:0];
                bit_cnt_reg  <= bit_cnt_reg + CNT_W'(1);
            end

            if (frame_last && cmd_ok) begin
                rx_data_reg <= word_next;
                if (state_reg == READ_ADD) rd_addr_flag_reg <= 1'b1;
            end

            if (bus.SS_n || miso_load) begin
                rd_armed_reg <= 1'b0;
            end else if (frame_last && cmd_ok && (state_reg == READ_DATA)) begin
                rd_armed_reg <= 1'b1;
            end

            // The address is consumed only by a complete readout.
            if (miso_done) rd_addr_flag_reg <= 1'b0;
        end
    end

    assign miso_load = rd_armed_reg && bus.tx_valid && !bus.SS_n;

    spi_miso_shifter #(
        .DATA_W (DATA_W)
    ) u_miso_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.SS_n),
        .load  (miso_load),
        .din   (bus.tx_data),
        .miso  (miso_bit),
        .done  (miso_done)
    );

    assign bus.MISO     = miso_bit;
    assign bus.rx_data  = rx_data_reg;
    assign bus.rx_valid = rx_valid_reg;
endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Directed scoreboard bench for spi_slave. Stimulus pushes expected command
// words and timed MISO values into queues; a negedge monitor pops and compares
// whenever rx_valid is presented or a timed MISO expectation falls due.
// -----------------------------------------------------------------------------
module tb_spi_slave;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if bus ();

    spi_slave dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int   c;
        logic b;
    } miso_exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [9:0]  rx_q[$];
    miso_exp_t   miso_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [9:0] exp_word;
        miso_exp_t  e;
        if (bus.rx_valid === 1'b1) begin
            n_tests++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx_unexpected: got rx_data=%h, required no rx_valid (cycle %0d)",
                         bus.rx_data, cyc);
            end else begin
                exp_word = rx_q.pop_front();
                if (bus.rx_data !== exp_word) begin
                    n_fail++;
                    $display("FAIL rx_data: got %h, required %h (cycle %0d)",
                             bus.rx_data, exp_word, cyc);
                end else begin
                    $display("[TB] rx word %h ok (cycle %0d)", bus.rx_data, cyc);
                end
            end
            n_tests++;
            if (bus.cmd_err !== 1'b0) begin
                n_fail++;
                $display("FAIL cmd_err_with_valid: got %b, required 0", bus.cmd_err);
            end
        end
        while (miso_q.size() > 0 && miso_q[0].c <= cyc) begin
            e = miso_q.pop_front();
            n_tests++;
            if (e.c != cyc || bus.MISO !== e.b) begin
                n_fail++;
                $display("FAIL miso: got %b at cycle %0d, required %b at cycle %0d",
                         bus.MISO, cyc, e.b, e.c);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("[TB] %s ok (%h)", name, act);
        end
    endtask

    task automatic push_miso(input int c, input logic b);
        miso_exp_t e;
        e.c = c;
        e.b = b;
        miso_q.push_back(e);
    endtask

    // Byte d appears MSB first starting at cycle first, then MISO returns to 0.
    task automatic expect_miso(input logic [7:0] d, input int first);
        for (int i = 0; i < 8; i++) push_miso(first + i, d[7-i]);
        push_miso(first + 8, 1'b0);
    endtask

    task automatic expect_quiet(input int n);
        for (int i = 1; i <= n; i++) push_miso(cyc + i, 1'b0);
    endtask

    // Called at a negedge; returns at the negedge just after the last payload bit.
    task automatic send_frame(input logic sel, input logic [9:0] p, input bit expect_rx);
        if (expect_rx) rx_q.push_back(p);
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        tick();
        bus.MOSI = sel;
        tick();
        for (int i = 9; i >= 0; i--) begin
            bus.MOSI = p[i];
            tick();
        end
    endtask

    task automatic deselect();
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.SS_n     = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (3) tick();

        check("reset_miso",     32'(bus.MISO),     32'd0);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_rx_data",  32'(bus.rx_data),  32'd0);
        check("reset_cmd_err",  32'(bus.cmd_err),  32'd0);
        rst_n = 1'b1;
        tick();

`ifdef SPI_CMD_CHECK_EN
        // Read-address path carrying a read-data code: rejected.
        send_frame(1'b1, 10'h300, 1'b0);
        check("cmderr_pulse",    32'(bus.cmd_err),  32'd1);
        check("cmderr_no_valid", 32'(bus.rx_valid), 32'd0);
        tick();
        check("cmderr_drop",     32'(bus.cmd_err),  32'd0);
        deselect();
`endif

        // Write address, MISO silent throughout
        expect_quiet(14);
        send_frame(1'b0, 10'h0A5, 1'b1);
        tick();
        check("wr_addr_valid_drop", 32'(bus.rx_valid), 32'd0);
        deselect();

        // Write data with trailing bits while still selected
        send_frame(1'b0, 10'h13C, 1'b1);
        bus.MOSI = 1'b1;
        repeat (4) tick();
        deselect();

        // Read address, then read data with readout of C3
        send_frame(1'b1, 10'h207, 1'b1);
        deselect();
        send_frame(1'b1, 10'h300, 1'b1);
        tick();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hC3;
        n = cyc;
        expect_miso(8'hC3, n + 1);
        for (int i = 10; i <= 13; i++) push_miso(n + i, 1'b0);
        tick();
        bus.tx_data = 8'h7E;          // must be ignored during and after shifting
        repeat (12) tick();
        bus.tx_valid = 1'b0;
        deselect();

        // Flag cleared by the readout: select=1 goes to READ_ADD, no readout
        send_frame(1'b1, 10'h2AA, 1'b1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        expect_quiet(10);
        repeat (10) tick();
        bus.tx_valid = 1'b0;
        deselect();

        // Abort after 5 payload bits, then a full frame
        bus.SS_n = 1'b0;
        bus.MOSI = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.MOSI = 1'b1;
            tick();
        end
        deselect();
        send_frame(1'b0, 10'h155, 1'b1);
        deselect();

        // Reset in the middle of a readout (flag set by the 2AA frame)
        send_frame(1'b1, 10'h3F0, 1'b1);
        tick();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA5;
        n = cyc;
        push_miso(n + 1, 1'b1);
        push_miso(n + 2, 1'b0);
        push_miso(n + 3, 1'b1);
        push_miso(n + 4, 1'b0);
        push_miso(n + 5, 1'b0);
        tick();
        bus.tx_valid = 1'b0;
        tick();
        tick();
        rst_n    = 1'b0;
        bus.SS_n = 1'b1;
        tick();
        check("midread_reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // After reset the flag is clear: READ_ADD, tx_valid ignored
        send_frame(1'b1, 10'h211, 1'b1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        expect_quiet(10);
        repeat (10) tick();
        bus.tx_valid = 1'b0;
        deselect();

        // Flag now set: full readout of 5A
        send_frame(1'b1, 10'h301, 1'b1);
        tick();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h5A;
        n = cyc;
        expect_miso(8'h5A, n + 1);
        tick();
        bus.tx_valid = 1'b0;
        repeat (10) tick();
        deselect();

        repeat (4) tick();
        check("rx_queue_drained",   32'(rx_q.size()),   32'd0);
        check("miso_queue_drained", 32'(miso_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Serial front end for the SPI-to-RAM path.
- Deserialises MOSI frames into 10-bit command words (rx_data/rx_valid) for the single-port RAM controller.
- Serialises the 8-bit read data returned by the RAM (tx_data/tx_valid) onto MISO.
- The system clock doubles as SCK; one bit is transferred per clk edge while SS_n is low.

Parameters:
- FRAME_W, 10, payload width of one command word (2 command bits + 8 address/data bits).
- DATA_W, 8, width of read data returned on MISO.

Ports:
- clk  in  1  system clock / SCK; all sampling on rising edge
- rst_n  in  1  synchronous active-low reset
- SS_n  in  1  slave select, active low; frame boundary
- MOSI  in  1  serial input, MSB first
- MISO  out  1  serial output, MSB first
- rx_data  out  FRAME_W  assembled command word to RAM
- rx_valid  out  1  one-cycle strobe qualifying rx_data
- tx_data  in  DATA_W  read data from RAM
- tx_valid  in  1  qualifies tx_data; sampled only while awaiting read data
- cmd_err  out  1  one-cycle error strobe; constant 0 unless SPI_CMD_CHECK_EN

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, rx_data=0, rx_valid=0, MISO=0, cmd_err=0, bit counter=0, rd_addr_flag=0.
- Frame format: 1 select bit, then FRAME_W payload bits, all MSB first.
  - Select bit 0 = write path.
  - Select bit 1 = read path.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD (edge E0).
- CHK_CMD, at edge E1, samples MOSI as the select bit:
  - 0 -> WRITE.
  - 1 with rd_addr_flag=0 -> READ_ADD.
  - 1 with rd_addr_flag=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA payload:
  - Edges E2..E11 shift payload bits 9..0 into the shift register.
  - At E11: rx_data <= full word, rx_valid <= 1.
  - At E12: rx_valid <= 0. Exactly one cycle high per complete frame.
- READ_ADD: rd_addr_flag set at E11 (same edge as rx_valid).
- READ_DATA, after E11, waits for tx_valid:
  - First edge Ek with tx_valid=1: load tx_data, MISO <= tx_data[7].
  - Ek+1..Ek+7: MISO <= bits 6..0.
  - Ek+8: MISO <= 0, rd_addr_flag cleared; remain in READ_DATA until SS_n=1.
  - tx_valid is ignored before E11, during shifting, and after shifting completes.
- SS_n=1 in any non-IDLE state forces IDLE at the next edge:
  - counter cleared, MISO <= 0;
  - no rx_valid for the partial frame;
  - rd_addr_flag unchanged, except it is cleared only after a full 8-bit readout.
- SS_n held low after a frame completes in WRITE/READ_ADD: remain in state, extra MOSI bits ignored, no further rx_valid.
- A read without a prior address (select=1, flag=0) always goes to READ_ADD; this is the only way the flag is set.
- Reset mid-frame or mid-readout: immediate return to reset values; RAM sees no strobe.

Optional Feature:
- Macro SPI_CMD_CHECK_EN.
- Defined: at E11, payload[9:8] is checked against state.
  - Allowed: WRITE 00/01, READ_ADD 10, READ_DATA 11.
  - Mismatch: rx_valid suppressed, cmd_err=1 for one cycle, rd_addr_flag not modified, readout not started.
- Undefined: no check; cmd_err tied 0; all words forwarded.

Decomposition:
- Package spi_pkg holds:
  - state enum;
  - FRAME_W and DATA_W defaults;
  - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- One sub-module: spi_miso_shifter (load on tx_valid, 8-bit MSB-first shift, done flag).
- FSM, bit counter and receive shift register stay in spi_slave.

Test Plan:
- Write address: SS_n low, send 0 then 00_1010_0101 -> rx_data=10'h0A5, rx_valid high only at E11->E12, no MISO activity.
- Write data: send 0 then 01_0011_1100 -> rx_data=10'h13C, one rx_valid pulse.
- Read sequence:
  - Send 1 + 10_0000_0111 -> rx_data=10'h207, flag set.
  - SS_n high, then low; send 1 + 11_0000_0000 -> rx_data=10'h300.
  - tx_valid=1 with tx_data=8'hC3 two cycles later -> MISO 1,1,0,0,0,0,1,1 on following edges, then 0; flag cleared.
- Abort: SS_n high after 5 payload bits -> IDLE next edge, no rx_valid; next full frame decodes correctly.
- Reset mid-readout after 3 MISO bits -> MISO=0, state IDLE, flag=0; next select=1 routes to READ_ADD.
- With SPI_CMD_CHECK_EN: READ_ADD frame carrying 11_xxxx -> no rx_valid, cmd_err pulse, flag stays 0.
